// File: rtl/dcache_lsu.sv
// Load/store unit: computes the effective address, splits misaligned half/word
// accesses into ascending byte accesses, and merges/extends load data.
module dcache_lsu #(
  parameter int DATABITS    = 32,
  parameter int ADDRBITS    = 32,
  parameter int TIMEOUTBITS = 8,
  parameter int MAXWAIT     = 'd255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lsu_start,
  input  logic                lsu_store,
  input  logic [2:0]          lsu_funct3,
  input  logic [ADDRBITS-1:0] lsu_base,
  input  logic [11:0]         lsu_offset,
  input  logic [DATABITS-1:0] lsu_wdata,
  output logic                lsu_busy,
  output logic                lsu_done,
  output logic                lsu_error,
  output logic [DATABITS-1:0] lsu_rdata,
  output logic [ADDRBITS-1:0] dcache_addr,
  output logic [DATABITS-1:0] dcache_in,
  output logic [1:0]          dcache_wordlen,
  output logic                dcache_rdreq,
  output logic                dcache_wrreq,
  input  logic [DATABITS-1:0] dcache_out,
  input  logic                dcache_out_valid
);

  // Core handshake: lsu_start is sampled only while idle (lsu_busy=0); the
  // request completes with a single-cycle lsu_done, with lsu_error/lsu_rdata
  // valid in that cycle. A start while busy is dropped, not queued.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [TIMEOUTBITS-1:0] WAIT_LAST = TIMEOUTBITS'(MAXWAIT - 1);

  logic [1:0]             state;
  logic                   store_q;
  logic [2:0]             funct3_q;
  logic [DATABITS-1:0]    wdata_q;
  logic [1:0]             sub_idx;
  logic [1:0]             last_idx;
  logic [TIMEOUTBITS-1:0] wait_cnt;
  logic [DATABITS-1:0]    merge_q;

  logic [ADDRBITS-1:0] ea;
  logic                legal;
  logic                misaligned;
  logic [1:0]          start_len;
  logic [1:0]          start_last;
  logic [DATABITS-1:0] start_in;
  logic [1:0]          next_idx;
  logic [7:0]          next_byte;
  logic [7:0]          lane_byte;
  logic [15:0]         lane_half;
  logic [DATABITS-1:0] merge_next;
  logic                last_sub;

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] m);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {{24{m[7]}}, m[7:0]};
      3'b001:  r = {{16{m[15]}}, m[15:0]};
      3'b100:  r = {24'h0, m[7:0]};
      3'b101:  r = {16'h0, m[15:0]};
      default: r = m;
    endcase
    return r;
  endfunction

  always_comb begin
    ea = lsu_base + {{(ADDRBITS-12){lsu_offset[11]}}, lsu_offset};
    legal = 1'b0;
    case (lsu_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !lsu_store;
      default:                legal = 1'b0;
    endcase
    misaligned = ((lsu_funct3[1:0] == 2'b01) && ea[0]) ||
                 ((lsu_funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
    start_len  = misaligned ? 2'b00 : lsu_funct3[1:0];
    start_last = 2'd0;
    if (misaligned) start_last = (lsu_funct3[1:0] == 2'b10) ? 2'd3 : 2'd1;
    // Misaligned accesses begin with byte 0; aligned ones replicate across lanes.
    if (misaligned || lsu_funct3[1:0] == 2'b00) start_in = {4{lsu_wdata[7:0]}};
    else if (lsu_funct3[1:0] == 2'b01)          start_in = {2{lsu_wdata[15:0]}};
    else                                        start_in = lsu_wdata;
  end

  always_comb begin
    next_idx  = sub_idx + 2'd1;
    next_byte = wdata_q[{next_idx, 3'b000} +: 8];
    lane_byte = dcache_out[{dcache_addr[1:0], 3'b000} +: 8];
    lane_half = dcache_out[{dcache_addr[1], 4'b0000} +: 16];
    last_sub  = (sub_idx == last_idx);
    merge_next = merge_q;
    case (dcache_wordlen)
      2'b00:   merge_next[{sub_idx, 3'b000} +: 8] = lane_byte;
      2'b01:   merge_next = {16'h0, lane_half};
      default: merge_next = dcache_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      store_q        <= 1'b0;
      funct3_q       <= 3'b000;
      wdata_q        <= '0;
      sub_idx        <= 2'd0;
      last_idx       <= 2'd0;
      wait_cnt       <= '0;
      merge_q        <= '0;
      lsu_error      <= 1'b0;
      lsu_rdata      <= '0;
      dcache_addr    <= '0;
      dcache_in      <= '0;
      dcache_wordlen <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (lsu_start) begin
            store_q  <= lsu_store;
            funct3_q <= lsu_funct3;
            wdata_q  <= lsu_wdata;
            sub_idx  <= 2'd0;
            merge_q  <= '0;
            if (legal) begin
              dcache_addr    <= ea;
              dcache_wordlen <= start_len;
              last_idx       <= start_last;
              if (lsu_store) dcache_in <= start_in;
              state <= S_ISSUE;
            end else begin
              lsu_error <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_ISSUE: begin
          if (store_q) begin
            if (last_sub) begin
              lsu_error <= 1'b0;
              state     <= S_DONE;
            end else begin
              sub_idx     <= next_idx;
              dcache_addr <= dcache_addr + 1'b1;
              dcache_in   <= {4{next_byte}};
            end
          end else begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dcache_out_valid) begin
            merge_q <= merge_next;
            if (last_sub) begin
              lsu_rdata <= extend(funct3_q, merge_next);
              lsu_error <= 1'b0;
              state     <= S_DONE;
            end else begin
              sub_idx     <= next_idx;
              dcache_addr <= dcache_addr + 1'b1;
              state       <= S_ISSUE;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            // The counter has spent MAXWAIT cycles in WAIT: give up.
            lsu_rdata <= '0;
            lsu_error <= 1'b1;
            state     <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign lsu_busy     = (state != S_IDLE);
  assign lsu_done     = (state == S_DONE);
  assign dcache_rdreq = (state == S_ISSUE) && !store_q;
  assign dcache_wrreq = (state == S_ISSUE) && store_q;

endmodule
